// File: rtl/tone_sequencer_if.sv
// Peripheral register bus: separate read and write channels, zero-wait grants,
// registered read data.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/tone_sequencer.sv
// Queued square-wave tone generator: the CPU pushes {duration, half-period}
// notes into a FIFO and the sequencer plays them back-to-back on SPK_KX.
//
// state  | meaning
// IDLE   | speaker low, waiting for EN with a non-empty queue
// LOAD   | pop queue head into cur, restart tone/ms counters (1 cycle)
// PLAY   | square wave (or rest when div==0) until dur ms have elapsed
module tone_sequencer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1_000_000,
  parameter int DIV_W      = 16,
  parameter int DUR_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic     CLK0,
  input  logic     RST0,
  output logic     SPK_KX,
  output logic     PLAYING,
  output logic     IRQ,
  naive_bus.slave  bus
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int MS_TICKS = TICK_HZ / 1000;
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int MS_W     = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int NOTE_W   = DUR_W + DIV_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PRE_W-1:0]  pre_q;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [DIV_W-1:0]  tone_q, tone_d;
  logic [DUR_W-1:0]  durc_q, durc_d;
  logic              spk_q, spk_d;
  logic [NOTE_W-1:0] cur_q, cur_d;
  logic              en_q, irq_en_q, ovf_q, done_q;
  logic [31:0]       rd_data_q;
  logic [NOTE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              note_wr, ctrl_wr, stat_wr, flush;
  logic              empty, full, pop, push_ok, ovf_set, done_set;
  logic              tick, ms_last, ms_strobe;
  logic [NOTE_W-1:0] head, note_in;
  logic [DUR_W-1:0]  cur_dur;
  logic [DIV_W-1:0]  cur_div;
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign bus.rd_gnt  = bus.rd_req;
  assign bus.wr_gnt  = bus.wr_req;
  assign bus.rd_data = rd_data_q;

  assign note_wr = bus.wr_req && (bus.wr_addr[3:2] == 2'd0);
  assign ctrl_wr = bus.wr_req && (bus.wr_addr[3:2] == 2'd1);
  assign stat_wr = bus.wr_req && (bus.wr_addr[3:2] == 2'd2);
  assign flush   = ctrl_wr && bus.wr_data[2];
  assign note_in = {bus.wr_data[16 +: DUR_W], bus.wr_data[DIV_W-1:0]};

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop     = (state_q == S_LOAD) && !flush;
  // A push into a full queue still fits when the head leaves in the same cycle.
  assign push_ok = note_wr && !flush && (!full || pop);
  assign ovf_set = note_wr && !flush && full && !pop;
  assign head    = mem[rd_ptr_q];

  assign tick      = (pre_q == PRE_W'(PRESCALE - 1));
  assign ms_last   = (ms_q == MS_W'(MS_TICKS - 1));
  assign ms_strobe = tick && ms_last;
  assign cur_dur   = cur_q[NOTE_W-1:DIV_W];
  assign cur_div   = cur_q[DIV_W-1:0];

  assign unused_bits = ^{bus.rd_addr[31:4], bus.rd_addr[1:0],
                         bus.wr_addr[31:4], bus.wr_addr[1:0], bus.wr_data};

  always_comb begin
    state_d  = state_q;
    spk_d    = spk_q;
    tone_d   = tone_q;
    durc_d   = durc_q;
    cur_d    = cur_q;
    done_set = 1'b0;
    ms_d     = ms_q;
    if (tick) ms_d = ms_last ? '0 : ms_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        spk_d = 1'b0;
        if (en_q && !empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_d   = head;
        tone_d  = '0;
        durc_d  = '0;
        ms_d    = '0;
        spk_d   = 1'b0;
        state_d = (head[NOTE_W-1:DIV_W] == '0) ? S_IDLE : S_PLAY;
      end
      S_PLAY: begin
        if (tick && (cur_div != '0)) begin
          if (tone_q == cur_div - DIV_W'(1)) begin
            spk_d  = !spk_q;
            tone_d = '0;
          end else begin
            tone_d = tone_q + DIV_W'(1);
          end
        end
        // End of note overrides a coincident toggle so the pin always parks low.
        if (ms_strobe) begin
          durc_d = durc_q + DUR_W'(1);
          if (durc_q == cur_dur - DUR_W'(1)) begin
            spk_d = 1'b0;
            if (en_q && !empty) begin
              state_d = S_LOAD;
            end else begin
              state_d  = S_IDLE;
              done_set = empty;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        spk_d   = 1'b0;
      end
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      spk_d    = 1'b0;
      done_set = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr[3:2])
      2'd1:    rd_mux = {29'd0, 1'b0, irq_en_q, en_q};
      2'd2:    rd_mux = {16'd0, 8'(count_q), 3'd0, done_q, ovf_q, PLAYING, full, empty};
      2'd3:    rd_mux = (state_q == S_PLAY) ? 32'(cur_q) : 32'd0;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK0 or negedge RST0) begin
    if (!RST0) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      ms_q      <= '0;
      tone_q    <= '0;
      durc_q    <= '0;
      spk_q     <= 1'b0;
      cur_q     <= '0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      ms_q    <= ms_d;
      tone_q  <= tone_d;
      durc_q  <= durc_d;
      spk_q   <= spk_d;
      cur_q   <= cur_d;
      if (ctrl_wr) begin
        en_q     <= bus.wr_data[0];
        irq_en_q <= bus.wr_data[1];
      end
      if (ovf_set)      ovf_q <= 1'b1;
      else if (stat_wr) ovf_q <= 1'b0;
      if (done_set)     done_q <= 1'b1;
      else if (stat_wr) done_q <= 1'b0;
      if (bus.rd_req) rd_data_q <= rd_mux;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK0) begin
    if (push_ok) mem[wr_ptr_q] <= note_in;
  end

  assign SPK_KX  = spk_q;
  assign PLAYING = (state_q == S_PLAY);
  assign IRQ     = irq_en_q && done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer, scaled to 4 clk/tick and 10 ticks/ms
// so every note is a few dozen cycles long.
module tb_tone_sequencer;
  localparam int PRE = 4;
  localparam int MS  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spk, playing, irq;
  naive_bus bus_if ();

  tone_sequencer #(.CLK_HZ(40_000), .TICK_HZ(10_000), .DIV_W(16), .DUR_W(16), .FIFO_DEPTH(8)) dut (
    .CLK0(clk), .RST0(rst_n), .SPK_KX(spk), .PLAYING(playing), .IRQ(irq), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int edge_q[$];
  logic spk_prev = 1'b0;
  logic [31:0] rd_exp_q[$];
  string rd_name_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spk !== spk_prev) edge_q.push_back(cyc);
    spk_prev = spk;
  end

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = {28'd0, addr};
    bus_if.wr_data = data;
    @(negedge clk);
    bus_if.wr_req  = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    @(negedge clk);
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = {28'd0, addr};
    @(negedge clk);
    bus_if.rd_req  = 1'b0;
    check(rd_name_q.pop_front(), bus_if.rd_data, rd_exp_q.pop_front());
  endtask

  // which: 0 PLAYING, 1 SPK_KX, 2 IRQ
  task automatic wait_for(input string name, input int which, input logic val, input int budget);
    logic s;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      s = (which == 0) ? playing : (which == 1) ? spk : irq;
      if (s === val) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout after %0d cycles waiting for %0b", name, budget, val);
  endtask

  vec_t vec[18];
  int plen;

  initial begin
    vec[0]  = '{1'b1, 4'h4, 32'h0, "ctrl_off"};
    for (int i = 0; i < 9; i++)
      vec[1+i] = '{1'b1, 4'h0, {16'(i + 1), 16'(i + 10)}, "push"};
    vec[10] = '{1'b0, 4'h8, 32'h0000_080A, "status_full_ovf"};
    vec[11] = '{1'b0, 4'h0, 32'h0, "note_reads_zero"};
    vec[12] = '{1'b0, 4'hC, 32'h0, "cur_idle"};
    vec[13] = '{1'b1, 4'h8, 32'hFFFF_FFFF, "status_clear"};
    vec[14] = '{1'b0, 4'h8, 32'h0000_0802, "status_ovf_cleared"};
    vec[15] = '{1'b1, 4'h4, 32'h6, "flush"};
    vec[16] = '{1'b0, 4'h8, 32'h0000_0001, "status_flushed"};
    vec[17] = '{1'b0, 4'h4, 32'h2, "ctrl_readback"};

    bus_if.rd_req = 1'b0; bus_if.rd_addr = '0;
    bus_if.wr_req = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_spk", 32'(spk), 32'h0);
    check("rst_playing", 32'(playing), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    bus_read(4'h4, 32'h0, "rst_ctrl");
    bus_read(4'h8, 32'h1, "rst_status");
    bus_read(4'hC, 32'h0, "rst_cur");

    // Single note {dur=2, div=5}: toggles every 5 ticks, 4 edges, then low.
    bus_write(4'h0, 32'h0002_0005);
    bus_read(4'h8, 32'h0000_0100, "status_one_queued");
    edge_q.delete();
    bus_write(4'h4, 32'h3);
    wait_for("note1_start", 0, 1'b1, 20);
    plen = 1;
    for (int i = 0; i < 200 && playing; i++) begin
      @(negedge clk);
      if (playing) plen++;
    end
    repeat (4) @(negedge clk);
    check("note1_edges", 32'(edge_q.size()), 32'd4);
    for (int i = 1; i < 4 && i < edge_q.size(); i++)
      check("note1_halfperiod", 32'(edge_q[i] - edge_q[i-1]), 32'(5 * PRE));
    check_range("note1_length", plen, (2 * MS - 1) * PRE + 1, 2 * MS * PRE);
    check("note1_spk_low", 32'(spk), 32'h0);
    check("note1_irq", 32'(irq), 32'h1);
    bus_read(4'h8, 32'h0000_0011, "status_done");
    bus_write(4'h8, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    // Overflow and flush via register vectors.
    for (int i = 0; i < 18; i++) begin
      if (vec[i].wr) bus_write(vec[i].addr, vec[i].data);
      else           bus_read(vec[i].addr, vec[i].data, vec[i].name);
    end
    check("no_play_after_flush", 32'(playing), 32'h0);

    // Queue {1,5},{1,0},{0,7},{1,2}: tone, rest, skipped note, faster tone.
    bus_write(4'h0, 32'h0001_0005);
    bus_write(4'h0, 32'h0001_0000);
    bus_write(4'h0, 32'h0000_0007);
    bus_write(4'h0, 32'h0001_0002);
    bus_read(4'h8, 32'h0000_0400, "status_four_queued");
    edge_q.delete();
    bus_write(4'h4, 32'h3);
    wait_for("queue_done_irq", 2, 1'b1, 1000);
    check("queue_edges", 32'(edge_q.size()), 32'd6);
    if (edge_q.size() == 6) begin
      check("queue_n1_half", 32'(edge_q[1] - edge_q[0]), 32'(5 * PRE));
      check_range("queue_rest_gap", edge_q[2] - edge_q[1], MS * PRE, MS * PRE + 20);
      check("queue_n4_half_a", 32'(edge_q[3] - edge_q[2]), 32'(2 * PRE));
      check("queue_n4_half_b", 32'(edge_q[5] - edge_q[4]), 32'(2 * PRE));
    end
    bus_read(4'h8, 32'h0000_0011, "queue_status_done");

    // Flush mid-note with three notes still queued.
    bus_write(4'h8, 32'h0);
    bus_write(4'h4, 32'h0);
    for (int i = 0; i < 4; i++) bus_write(4'h0, 32'h0005_0003);
    bus_write(4'h4, 32'h1);
    wait_for("flush_note_start", 0, 1'b1, 20);
    repeat (30) @(negedge clk);
    bus_read(4'h8, 32'h0000_0304, "status_mid_note");
    bus_write(4'h4, 32'h5);
    check("flush_spk", 32'(spk), 32'h0);
    check("flush_playing", 32'(playing), 32'h0);
    bus_read(4'h8, 32'h0000_0001, "flush_status");
    repeat (60) @(negedge clk);
    check("flush_stays_idle", 32'(playing), 32'h0);

    // CUR readback during a note.
    bus_write(4'h0, 32'h0003_00C8);
    wait_for("cur_note_start", 0, 1'b1, 20);
    bus_read(4'hC, 32'h0003_00C8, "cur_playing");
    bus_write(4'h4, 32'h4);
    bus_read(4'hC, 32'h0, "cur_after_flush");

    // Asynchronous reset between clock edges while the speaker is high.
    bus_write(4'h0, 32'h0003_0003);
    bus_write(4'h0, 32'h0003_0003);
    bus_write(4'h4, 32'h1);
    wait_for("rst_note_high", 1, 1'b1, 200);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_spk", 32'(spk), 32'h0);
    check("async_rst_playing", 32'(playing), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(4'h8, 32'h1, "async_rst_status");
    bus_read(4'h4, 32'h0, "async_rst_ctrl");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
